bp_update_ctrl: RTL and testbench
=================================

# bp_update_ctrl

Sequencing controller between the execute stage and the global-history branch predictor. It buffers resolved-branch outcomes in a small in-order FIFO and drains them to the predictor's update port one per cycle under a valid/ready handshake. It detects mispredictions at acceptance, issues a single-cycle flush request to the front end, and holds off new resolutions for a fixed recovery window. It also keeps saturating branch and mispredict counters for performance monitoring.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- RECOVER_CYCLES, 2, cycles the block spends in RECOVER after a mispredict; ≥ 1
- CNT_W, 32, width of the performance counters

- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset; the only clock is clk
- res_valid  in  1  execute stage presents a resolved branch
- res_taken  in  1  actual outcome
- res_pred  in  1  prediction made at fetch for this branch
- res_ready  out  1  block accepts the resolution this cycle
- bp_valid  out  1  update presented to predictor (drives predictor valid)
- bp_taken  out  1  outcome for the update (drives predictor actual_branch_taken)
- bp_ready  in  1  predictor consumes the update this cycle
- flush_req  out  1  one-cycle pulse: front end must flush and redirect
- fifo_empty  out  1  no pending updates
- branch_cnt  out  CNT_W  accepted branches, saturating
- mispred_cnt  out  CNT_W  accepted mispredicts, saturating

## Operation
- Accept: res_valid && res_ready. Enqueue res_taken at the tail, then increment branch_cnt.
- Mispredict: res_taken != res_pred on an accepted cycle. Increment mispred_cnt. flush_req is registered high the next cycle for exactly one cycle. FSM enters RECOVER.
- FSM states:
  - RUN → RECOVER on an accepted mispredict.
  - RECOVER: down-counter loaded with RECOVER_CYCLES−1. Stays until the counter is 0, then returns to RUN. Exactly RECOVER_CYCLES cycles are spent in RECOVER.
- res_ready = (state == RUN) && !full. No same-cycle pass-through: when full, res_ready is low even if a dequeue occurs that cycle.
- Drain: bp_valid = !empty and bp_taken = head entry. Dequeue on bp_valid && bp_ready. Draining continues in every state, including RECOVER.
- Order: strictly FIFO. The predictor sees updates in resolution order.
- Pointers: log2(DEPTH) bits plus a wrap bit. full when indices match and wrap bits differ; empty when fully equal.
- Simultaneous enqueue and dequeue (not full): occupancy is unchanged and both pointers advance.
- Counters saturate at all-ones and do not wrap. A mispredict while branch_cnt is saturated still increments mispred_cnt until it saturates too.
- While bp_valid is high and bp_ready is low, bp_taken stays stable.

## Timing
- Reset (reset_n low at a clk edge) puts the block in this state:
  - FSM = RUN, FIFO empty, recover counter 0.
  - bp_valid=0, bp_taken=0, flush_req=0, fifo_empty=1, res_ready=1.
  - branch_cnt=0, mispred_cnt=0.
- Reset mid-operation discards pending updates, aborts RECOVER, and cancels a pending flush pulse.
- Latency from accept to bp_valid is 1 cycle (registered storage, no bypass).
- flush_req rises the cycle after the accepting edge. res_ready falls in that same cycle and stays low for RECOVER_CYCLES cycles.
- With bp_ready held high, throughput is one update per cycle and occupancy is at most 1.

## Structure
- The shared package bp_pkg holds:
  - typedef ctrl_state_t {RUN, RECOVER}.
  - The localparam/function for pointer width, $clog2(DEPTH).
- Sub-module bp_update_fifo: parameterised DEPTH×1-bit synchronous FIFO with full and empty flags. The top level holds the FSM, the flush register and the counters.

## Test plan
- Reset then idle: all outputs equal their reset values. Then 3 correct-prediction branches (taken=1/0/1, pred equal) with bp_ready=1 → bp_valid each following cycle, bp_taken 1,0,1, branch_cnt=3, flush_req never high.
- Mispredict (taken=1, pred=0) at cycle t → flush_req high only at t+1. res_ready low t+1..t+2 (RECOVER_CYCLES=2), high at t+3. The queued update still drains at t+1. mispred_cnt=1.
- bp_ready=0, enqueue 4 correct branches → res_ready=0 after the 4th. A 5th res_valid is not accepted. Raise bp_ready → 4 updates drain in order, then fifo_empty=1.
- Full FIFO with simultaneous dequeue and res_valid → no accept that cycle. Accept occurs the next cycle. Pointer wrap across 3× DEPTH entries preserves order.
- reset_n low during RECOVER with 2 entries queued → next cycle FIFO empty, bp_valid=0, res_ready=1, counters 0, no flush pulse.
- Force branch_cnt to 2^CNT_W−1 (CNT_W=4 instance, 16+ accepts) → it holds at 15. mispred_cnt saturates independently.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-predictor update controller and its FIFO.
package bp_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } ctrl_state_t;

    // Index width of a power-of-two FIFO; pointers carry one extra wrap bit on top.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Resolution and predictor-update handshakes of the branch update controller.
interface bp_update_ctrl_if;

    logic res_valid;
    logic res_taken;
    logic res_pred;
    logic res_ready;
    logic bp_valid;
    logic bp_taken;
    logic bp_ready;

    modport master (
        output res_valid, res_taken, res_pred, bp_ready,
        input  res_ready, bp_valid, bp_taken
    );

    modport slave (
        input  res_valid, res_taken, res_pred, bp_ready,
        output res_ready, bp_valid, bp_taken
    );

endinterface

// File: rtl/bp_update_fifo.sv
// In-order DEPTH x 1-bit FIFO holding resolved branch outcomes awaiting predictor update.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic clk,
    input  logic reset_n,
    input  logic wr_en,
    input  logic wr_data,
    input  logic rd_en,
    output logic rd_data,
    output logic full,
    output logic empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [DEPTH-1:0] mem;
    logic             do_wr;
    logic             do_rd;

    assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    // Gated so the update bit reads 0 whenever nothing is pending.
    assign rd_data = !empty && mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr[PW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Buffers resolved branches for the global-history predictor, flags mispredicts with a
// one-cycle flush and a recovery hold-off, and keeps saturating performance counters.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 32
)
(
    input  logic             clk,
    input  logic             reset_n,
    bp_update_ctrl_if.slave  bus,
    output logic             flush_req,
    output logic             fifo_empty,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int               RW       = $clog2(RECOVER_CYCLES + 1);
    localparam logic [RW-1:0]    REC_LOAD = RW'(RECOVER_CYCLES - 1);
    localparam logic [RW-1:0]    REC_ONE  = RW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ctrl_state_t   state;
    logic [RW-1:0] rec_cnt;
    logic          full;
    logic          accept;
    logic          mispredict;

    // No pass-through: a full FIFO refuses even if the head drains this cycle.
    assign bus.res_ready = (state == RUN) && !full;
    assign accept        = bus.res_valid && bus.res_ready;
    assign mispredict    = accept && (bus.res_taken != bus.res_pred);
    assign bus.bp_valid  = !fifo_empty;

    bp_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (accept),
        .wr_data (bus.res_taken),
        .rd_en   (bus.bp_ready),
        .rd_data (bus.bp_taken),
        .full    (full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= RUN;
            rec_cnt   <= '0;
            flush_req <= 1'b0;
        end else begin
            flush_req <= mispredict;
            case (state)
                RUN: begin
                    if (mispredict) begin
                        state   <= RECOVER;
                        rec_cnt <= REC_LOAD;
                    end
                end
                RECOVER: begin
                    if (rec_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        rec_cnt <= rec_cnt - REC_ONE;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (accept && !(&branch_cnt)) begin
                branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (mispredict && !(&mispred_cnt)) begin
                mispred_cnt <= mispred_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl against a queue-based reference model.
module tb_bp_update_ctrl;

    localparam int DEPTH          = 4;
    localparam int RECOVER_CYCLES = 2;
    localparam int CNT_W          = 4;
    localparam int CNT_MAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush_req;
    logic             fifo_empty;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int total = 0;
    int bad   = 0;

    bit exp_q[$];
    int model_cnt  = 0;
    int rec_left   = 0;
    int br_exp     = 0;
    int mp_exp     = 0;
    bit flush_exp  = 1'b0;
    bit started    = 1'b0;
    bit just_reset = 1'b0;

    bp_update_ctrl_if bus ();

    bp_update_ctrl #(
        .DEPTH          (DEPTH),
        .RECOVER_CYCLES (RECOVER_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .flush_req   (flush_req),
        .fifo_empty  (fifo_empty),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit t, input bit p, input bit r);
        @(posedge clk);
        #1;
        bus.res_valid = v;
        bus.res_taken = t;
        bus.res_pred  = p;
        bus.bp_ready  = r;
    endtask

    // Reference model: a queue of outcomes, a recovery countdown and two saturating tallies.
    always @(posedge clk) begin
        bit acc;
        bit deq;
        if (!reset_n) begin
            exp_q.delete();
            model_cnt  = 0;
            rec_left   = 0;
            br_exp     = 0;
            mp_exp     = 0;
            flush_exp  = 1'b0;
            started    = 1'b1;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            acc = bus.res_valid && (rec_left == 0) && (model_cnt < DEPTH);
            deq = (model_cnt > 0) && bus.bp_ready;
            flush_exp = 1'b0;
            if (rec_left > 0) rec_left--;
            if (acc) begin
                exp_q.push_back(bus.res_taken);
                model_cnt++;
                if (br_exp < CNT_MAX) br_exp++;
                if (bus.res_taken != bus.res_pred) begin
                    if (mp_exp < CNT_MAX) mp_exp++;
                    flush_exp = 1'b1;
                    rec_left  = RECOVER_CYCLES;
                end
            end
            if (deq) model_cnt--;
        end
    end

    // Monitor: compares every cycle and pops the scoreboard on each update handshake.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("res_ready",   32'(bus.res_ready), 32'((rec_left == 0) && (model_cnt < DEPTH)));
            checkOutput("bp_valid",    32'(bus.bp_valid),  32'(model_cnt > 0));
            checkOutput("fifo_empty",  32'(fifo_empty),    32'(model_cnt == 0));
            checkOutput("flush_req",   32'(flush_req),     32'(flush_exp));
            checkOutput("branch_cnt",  32'(branch_cnt),    32'(br_exp));
            checkOutput("mispred_cnt", 32'(mispred_cnt),   32'(mp_exp));
            if (just_reset) begin
                checkOutput("bp_taken_reset", 32'(bus.bp_taken), 32'(0));
            end
            if (bus.bp_valid === 1'b1) begin
                checkOutput("sb_has_entry", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    checkOutput("bp_taken", 32'(bus.bp_taken), 32'(exp_q[0]));
                    if (bus.bp_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bus.res_valid = 1'b0;
        bus.res_taken = 1'b0;
        bus.res_pred  = 1'b0;
        bus.bp_ready  = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Three correctly predicted branches, 1/0/1.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Mispredict, then keep offering a branch through the recovery window.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Fill with the predictor stalled; the fifth offer must be refused.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, i[0], i[0], 1'b0);
        end
        // Full FIFO with a dequeue in the same cycle: still no accept.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Pointer wrap over several FIFO depths with random stalls.
        for (int i = 0; i < 5 * DEPTH * 2; i++) begin
            bit t;
            t = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 3) != 0), t, t, 1'($urandom_range(0, 1)));
        end
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during RECOVER with two entries queued.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset coinciding with an offered mispredict cancels the would-be flush.
        @(posedge clk);
        #1;
        reset_n       = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        bus.res_pred  = 1'b0;
        @(posedge clk);
        #1;
        reset_n       = 1'b1;
        bus.res_valid = 1'b0;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic long enough to saturate both 4-bit counters.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end

        repeat (DEPTH + 2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("sb_drained", 32'(exp_q.size()), 32'(0));
        checkOutput("branch_sat", 32'(branch_cnt), 32'(CNT_MAX));
        checkOutput("mispred_sat", 32'(mispred_cnt), 32'(CNT_MAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
